// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: divisor inputs and tick output of the baud-rate generator.
// The DVSR_FRAC signal and its modport entries exist only when BAUD_FRAC_EN is defined.
interface uart_baud_gen_if #(
  parameter int CNT_W  = 11,
  parameter int FRAC_W = 4
);
  logic [CNT_W-1:0]  DVSR;
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] DVSR_FRAC;
`endif
  logic              tick;

`ifdef BAUD_FRAC_EN
  modport master (output DVSR, output DVSR_FRAC, input tick);
  modport slave  (input DVSR, input DVSR_FRAC, output tick);
`else
  modport master (output DVSR, input tick);
  modport slave  (input DVSR, output tick);
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divides clk by (DVSR+1) and emits a registered one-cycle tick
// per period. Optional macro BAUD_FRAC_EN adds a fractional divisor in
// sixteenths: a carry out of the accumulator stretches the next period by one cycle.
module uart_baud_gen #(
  parameter int CNT_W  = 11,
  parameter int FRAC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_baud_gen_if.slave  bif
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stall_q, stall_d;
`endif

  // Next-state: a pending stall takes priority, then wrap on cnt >= DVSR, else count up
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
`ifdef BAUD_FRAC_EN
    acc_d   = acc_q;
    stall_d = 1'b0;
    if (stall_q) begin
      cnt_d = cnt_q;
    end else
`endif
    if (cnt_q >= bif.DVSR) begin
      cnt_d  = '0;
      tick_d = 1'b1;
`ifdef BAUD_FRAC_EN
      {stall_d, acc_d} = {1'b0, acc_q} + {1'b0, bif.DVSR_FRAC};
`endif
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q   <= '0;
      stall_q <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
`ifdef BAUD_FRAC_EN
      acc_q   <= acc_d;
      stall_q <= stall_d;
`endif
    end
  end

  assign bif.tick = tick_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: scoreboard bench. Each test pushes the edge numbers at
// which a tick is expected (counted from the first edge with reset high),
// then compares tick every cycle against the queue head.
module tb_uart_baud_gen;
  localparam int CNT_W  = 11;
  localparam int FRAC_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   sb[$];
  logic exp_t;

  uart_baud_gen_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) bif ();

  uart_baud_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic hold_reset(input int n, input logic [CNT_W-1:0] dv);
    reset    = 1'b0;
    bif.DVSR = dv;
`ifdef BAUD_FRAC_EN
    bif.DVSR_FRAC = '0;
`endif
    sb.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    bif.DVSR = 11'd54;
`ifdef BAUD_FRAC_EN
    bif.DVSR_FRAC = '0;
`endif
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bif.tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d tick=%b expected=0", i, bif.tick);
      end
    end
    reset = 1'b1;
    for (int k = 1; k * 55 <= 1000; k++) sb.push_back(k * 55);
    checks++;
    if (sb.size() != 18) begin
      failures++;
      $display("FAIL reset_pulse_count got=%0d expected=18", sb.size());
    end
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL reset_period edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
    end
  endtask

  task automatic test_dvsr_small;
    hold_reset(2, 11'd0);
    for (int k = 1; k <= 12; k++) sb.push_back(k);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL dvsr0 edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
    end
    hold_reset(2, 11'd1);
    for (int k = 2; k <= 20; k += 2) sb.push_back(k);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL dvsr1 edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
    end
  endtask

  task automatic test_dvsr_change;
    hold_reset(2, 11'd54);
    // After edge 40 the counter holds 40; lowering DVSR to 10 wraps on edge 41
    for (int k = 41; k <= 100; k += 11) sb.push_back(k);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL dvsr_change edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
      if (i == 40) bif.DVSR = 11'd10;
    end
  endtask

  task automatic test_reset_mid;
    hold_reset(2, 11'd54);
    // Reset sampled low on edge 31; edge 32 is the first counting edge again
    sb.push_back(31 + 55);
    sb.push_back(31 + 110);
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL reset_mid edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
      if (i == 30) reset = 1'b0;
      if (i == 31) reset = 1'b1;
    end
  endtask

  task automatic test_max_dvsr;
    hold_reset(2, 11'd2047);
    sb.push_back(2048);
    sb.push_back(4096);
    for (int i = 1; i <= 4200; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL max_dvsr edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
    end
  endtask

`ifdef BAUD_FRAC_EN
  task automatic test_frac;
    int edge_n;
    int acc;
    int total;
    hold_reset(2, 11'd54);
    bif.DVSR_FRAC = 4'd4;
    edge_n = 55;
    acc    = 0;
    sb.push_back(edge_n);
    for (int n = 0; n < 16; n++) begin
      acc    = acc + 4;
      edge_n = edge_n + ((acc >= 16) ? 56 : 55);
      acc    = acc % 16;
      sb.push_back(edge_n);
    end
    total = edge_n - 55;
    checks++;
    if (total != 884) begin
      failures++;
      $display("FAIL frac_total got=%0d expected=884", total);
    end
    for (int i = 1; i <= 950; i++) begin
      @(posedge clk); #1;
      exp_t = (sb.size() != 0 && sb[0] == i);
      if (exp_t) void'(sb.pop_front());
      checks++;
      if (bif.tick !== exp_t) begin
        failures++;
        $display("FAIL frac edge=%0d tick=%b expected=%b", i, bif.tick, exp_t);
      end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bif.DVSR = '0;
`ifdef BAUD_FRAC_EN
    bif.DVSR_FRAC = '0;
`endif
    @(negedge clk);
    test_reset();
    test_dvsr_small();
    test_dvsr_change();
    test_reset_mid();
    test_max_dvsr();
`ifdef BAUD_FRAC_EN
    test_frac();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
